// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} dcache_state_t;

  // Fields are full-width; callers slice off the bits their geometry actually uses.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] word;
    logic [1:0]  byte_sel;
  } dcache_addr_t;

  function automatic int unsigned off_width(int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_width(int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(int unsigned lines, int unsigned words);
    return 32 - 2 - off_width(words) - idx_width(lines);
  endfunction

  function automatic dcache_addr_t split_addr(logic [31:0] addr, int unsigned off_w,
                                              int unsigned idx_w);
    dcache_addr_t s;
    logic [31:0]  w;
    w          = {2'b00, addr[31:2]};
    s.byte_sel = addr[1:0];
    s.word     = w & ((32'd1 << off_w) - 32'd1);
    w          = w >> off_w;
    s.index    = w & ((32'd1 << idx_w) - 32'd1);
    s.tag      = w >> idx_w;
    return s;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: asynchronous read, synchronous per-word write, valid clear and tag set.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned OffW = off_width(WORDS_PER_LINE),
  localparam int unsigned IdxW = idx_width(NUM_LINES),
  localparam int unsigned TagW = tag_width(NUM_LINES, WORDS_PER_LINE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IdxW-1:0] i_rd_index,
  input  logic [OffW-1:0] i_rd_word,
  output logic            o_rd_valid,
  output logic [TagW-1:0] o_rd_tag,
  output logic [31:0]     o_rd_data,
  input  logic            i_wr_en,
  input  logic [IdxW-1:0] i_wr_index,
  input  logic [OffW-1:0] i_wr_word,
  input  logic [31:0]     i_wr_data,
  input  logic            i_valid_clr,
  input  logic            i_tag_set,
  input  logic [IdxW-1:0] i_line_index,
  input  logic [TagW-1:0] i_tag
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TagW-1:0]      r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES][WORDS_PER_LINE];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index][i_rd_word];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_tag_set) begin
      r_valid[i_line_index] <= 1'b1;
    end else if (i_valid_clr) begin
      r_valid[i_line_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_tag_set) r_tag[i_line_index] <= i_tag;
    if (i_wr_en) r_data[i_wr_index][i_wr_word] <= i_wr_data;
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core and a
// request/ack memory bus. Holds the FSM, refill counter and memory-bus drivers.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dCacheAddr,
  input  logic [31:0] dCacheWriteData,
  input  logic        dCacheWriteEn,
  input  logic        dCacheReadEn,
  output logic [31:0] dCacheReadData,
  output logic        dCacheStall,
  output logic [31:0] memAddr,
  output logic        memReadEn,
  output logic        memWriteEn,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  input  logic        memAck
);

  localparam int unsigned OffW = off_width(WORDS_PER_LINE);
  localparam int unsigned IdxW = idx_width(NUM_LINES);
  localparam int unsigned TagW = tag_width(NUM_LINES, WORDS_PER_LINE);
  localparam logic [OffW-1:0] LastWord = OffW'(WORDS_PER_LINE - 1);

  dcache_state_t r_state;
  logic [OffW-1:0] r_cnt;
  logic            r_mem_read_en;
  logic            r_mem_write_en;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;

  dcache_addr_t    w_core;
  dcache_addr_t    w_mem;
  logic            w_idle;
  logic [IdxW-1:0] w_idx;
  logic [OffW-1:0] w_word;
  logic [TagW-1:0] w_cmp_tag;
  logic [TagW-1:0] w_rd_tag;
  logic [31:0]     w_rd_data;
  logic            w_rd_valid;
  logic            w_hit;
  logic            w_ack;
  logic            w_wr_en;
  logic [31:0]     w_wr_data;
  logic            w_tag_set;
  logic            w_valid_clr;
  logic            w_unused;

  assign w_core = split_addr(dCacheAddr, OffW, IdxW);
  assign w_mem  = split_addr(r_mem_addr, OffW, IdxW);
  assign w_idle = (r_state == IDLE);

  // Outside IDLE the latched memory address names the line being filled or written.
  assign w_idx     = w_idle ? w_core.index[IdxW-1:0] : w_mem.index[IdxW-1:0];
  assign w_word    = w_idle ? w_core.word[OffW-1:0]  : w_mem.word[OffW-1:0];
  assign w_cmp_tag = w_idle ? w_core.tag[TagW-1:0]   : w_mem.tag[TagW-1:0];
  assign w_hit     = w_rd_valid && (w_rd_tag == w_cmp_tag);
  assign w_ack     = memAck && (r_mem_read_en || r_mem_write_en);

  assign w_wr_en     = w_ack && ((r_state == REFILL) || ((r_state == WRITE) && w_hit));
  assign w_wr_data   = (r_state == REFILL) ? memReadData : r_mem_wdata;
  assign w_tag_set   = (r_state == REFILL) && w_ack && (r_cnt == LastWord);
  assign w_valid_clr = w_idle && dCacheReadEn && !dCacheWriteEn && !w_hit;

  assign w_unused = ^{w_core.byte_sel, w_core.tag[31:TagW], w_core.index[31:IdxW],
                      w_core.word[31:OffW], w_mem.byte_sel, w_mem.tag[31:TagW],
                      w_mem.index[31:IdxW], w_mem.word[31:OffW]};

  dcache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .i_rd_index   (w_idx),
    .i_rd_word    (w_word),
    .o_rd_valid   (w_rd_valid),
    .o_rd_tag     (w_rd_tag),
    .o_rd_data    (w_rd_data),
    .i_wr_en      (w_wr_en),
    .i_wr_index   (w_mem.index[IdxW-1:0]),
    .i_wr_word    (w_mem.word[OffW-1:0]),
    .i_wr_data    (w_wr_data),
    .i_valid_clr  (w_valid_clr),
    .i_tag_set    (w_tag_set),
    .i_line_index (w_idx),
    .i_tag        (w_mem.tag[TagW-1:0])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_mem_read_en  <= 1'b0;
      r_mem_write_en <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (dCacheWriteEn) begin
            r_state        <= WRITE;
            r_mem_write_en <= 1'b1;
            r_mem_addr     <= {dCacheAddr[31:2], 2'b00};
            r_mem_wdata    <= dCacheWriteData;
          end else if (dCacheReadEn && !w_hit) begin
            r_state       <= REFILL;
            r_cnt         <= '0;
            r_mem_read_en <= 1'b1;
            r_mem_addr    <= {dCacheAddr[31:2+OffW], {(OffW + 2){1'b0}}};
          end
        end
        REFILL: begin
          if (w_ack) begin
            r_cnt <= r_cnt + OffW'(1);
            if (r_cnt == LastWord) begin
              r_state       <= IDLE;
              r_mem_read_en <= 1'b0;
            end else begin
              r_mem_addr <= {r_mem_addr[31:2+OffW], r_cnt + OffW'(1), 2'b00};
            end
          end
        end
        WRITE: begin
          if (w_ack) begin
            r_state        <= IDLE;
            r_mem_write_en <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A write releases the core on its ack cycle so the held store is not reissued.
  always_comb begin
    dCacheStall = 1'b1;
    unique case (r_state)
      IDLE:    dCacheStall = dCacheWriteEn || (dCacheReadEn && !w_hit);
      REFILL:  dCacheStall = 1'b1;
      WRITE:   dCacheStall = !w_ack;
      default: dCacheStall = 1'b1;
    endcase
  end

  assign dCacheReadData = (w_idle && dCacheReadEn && !dCacheWriteEn && w_hit) ? w_rd_data : '0;
  assign memAddr        = r_mem_addr;
  assign memReadEn      = r_mem_read_en;
  assign memWriteEn     = r_mem_write_en;
  assign memWriteData   = r_mem_wdata;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios plus randomized traffic against a line-level model
// (the cache is a set of resident line base addresses; every load returns the memory value).
module tb_data_cache;

  localparam int unsigned NL  = 16;
  localparam int unsigned WPL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dCacheAddr = '0;
  logic [31:0] dCacheWriteData = '0;
  logic        dCacheWriteEn = 1'b0;
  logic        dCacheReadEn = 1'b0;
  logic [31:0] dCacheReadData;
  logic        dCacheStall;
  logic [31:0] memAddr;
  logic        memReadEn;
  logic        memWriteEn;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memAck;

  always #5 clk = ~clk;

  data_cache #(
    .NUM_LINES      (NL),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dCacheAddr      (dCacheAddr),
    .dCacheWriteData (dCacheWriteData),
    .dCacheWriteEn   (dCacheWriteEn),
    .dCacheReadEn    (dCacheReadEn),
    .dCacheReadData  (dCacheReadData),
    .dCacheStall     (dCacheStall),
    .memAddr         (memAddr),
    .memReadEn       (memReadEn),
    .memWriteEn      (memWriteEn),
    .memWriteData    (memWriteData),
    .memReadData     (memReadData),
    .memAck          (memAck)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        req_log[$];
  logic [31:0] mem[bit [31:0]];
  int          ack_delay = 2;
  int          resp_wait = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          m_valid[NL];
  logic [31:0] m_base[NL];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit log_ok(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input int n);
    if (req_log.size() != n) return 1'b0;
    foreach (req_log[i]) begin
      if (req_log[i].wr != wr) return 1'b0;
      if (req_log[i].addr !== addr + 32'(4 * i)) return 1'b0;
      if (wr && (req_log[i].data !== data)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // Memory responder: acks the current request after ack_delay cycles.
  initial begin
    memAck = 1'b0;
    memReadData = '0;
    forever begin
      @(negedge clk);
      memAck = 1'b0;
      if (memReadEn && memWriteEn) begin
        n_err++;
        $display("FAIL bus_exclusive: read and write both high at %0t", $time);
      end
      if (!rst && (memReadEn || memWriteEn)) begin
        resp_wait++;
        if (resp_wait >= ack_delay) begin
          resp_wait = 0;
          req_log.push_back('{memWriteEn, memAddr, memWriteEn ? memWriteData : 32'h0});
          if (memWriteEn) mem[memAddr] = memWriteData;
          else memReadData = mem_rd(memAddr);
          memAck = 1'b1;
        end
      end else begin
        resp_wait = 0;
      end
    end
  end

  task automatic core_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int stalls, output bit tmo);
    req_log.delete();
    stalls = 0;
    tmo = 1'b1;
    rdata = '0;
    @(negedge clk);
    dCacheAddr = addr;
    dCacheWriteEn = wr;
    dCacheReadEn = !wr;
    dCacheWriteData = wdata;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!dCacheStall) begin
        rdata = dCacheReadData;
        tmo = 1'b0;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    dCacheReadEn = 1'b0;
    dCacheWriteEn = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    dCacheReadEn = 1'b0;
    dCacheWriteEn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_vec++; if (dCacheStall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", dCacheStall); end
    n_vec++; if (memReadEn !== 1'b0) begin n_err++; $display("FAIL rst_memReadEn: got %b want 0", memReadEn); end
    n_vec++; if (memWriteEn !== 1'b0) begin n_err++; $display("FAIL rst_memWriteEn: got %b want 0", memWriteEn); end
    n_vec++; if (memAddr !== 32'h0) begin n_err++; $display("FAIL rst_memAddr: got %h want 0", memAddr); end
    n_vec++; if (memWriteData !== 32'h0) begin n_err++; $display("FAIL rst_memWriteData: got %h want 0", memWriteData); end
    n_vec++; if (dCacheReadData !== 32'h0) begin n_err++; $display("FAIL rst_readData: got %h want 0", dCacheReadData); end
    dCacheAddr = 32'h0000_0104;
    dCacheReadEn = 1'b1;
    #1;
    n_vec++; if (dCacheStall !== 1'b1) begin n_err++; $display("FAIL cold_stall_comb: got %b want 1", dCacheStall); end
    dCacheReadEn = 1'b0;
    #1;
    n_vec++; if (dCacheStall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b want 0", dCacheStall); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] rd; int st; bit tmo;
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    ack_delay = 2;
    core_op(1'b0, 32'h0000_0104, 32'h0, rd, st, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL cold_timeout: stall never dropped"); end
    n_vec++; if (log_ok(1'b0, 32'h100, 32'h0, 4) !== 1'b1) begin n_err++; $display("FAIL cold_requests: got %0d reqs want 4 reads from 00000100", req_log.size()); end
    n_vec++; if (st !== 1 + WPL * 2) begin n_err++; $display("FAIL cold_stall_cycles: got %0d want %0d", st, 1 + WPL * 2); end
    n_vec++; if (rd !== 32'hA1) begin n_err++; $display("FAIL cold_data: got %h want 000000a1", rd); end
    m_valid[0] = 1'b1; m_base[0] = 32'h100;
  endtask

  task automatic test_read_hit();
    logic [31:0] rd; int st; bit tmo;
    core_op(1'b0, 32'h0000_010C, 32'h0, rd, st, tmo);
    n_vec++; if (st !== 0) begin n_err++; $display("FAIL hit_stall: got %0d stall cycles want 0", st); end
    n_vec++; if (req_log.size() !== 0) begin n_err++; $display("FAIL hit_memory: got %0d reqs want 0", req_log.size()); end
    n_vec++; if (rd !== 32'hA3) begin n_err++; $display("FAIL hit_data: got %h want 000000a3", rd); end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int st; bit tmo;
    core_op(1'b1, 32'h0000_0108, 32'hDEAD_BEEF, rd, st, tmo);
    n_vec++; if (log_ok(1'b1, 32'h108, 32'hDEAD_BEEF, 1) !== 1'b1) begin n_err++; $display("FAIL wrhit_request: got %0d reqs want 1 write", req_log.size()); end
    n_vec++; if (st !== ack_delay) begin n_err++; $display("FAIL wrhit_stall: got %0d want %0d", st, ack_delay); end
    core_op(1'b0, 32'h0000_0108, 32'h0, rd, st, tmo);
    n_vec++; if (st !== 0 || req_log.size() !== 0) begin n_err++; $display("FAIL wrhit_reread_hit: got %0d stalls %0d reqs want 0 0", st, req_log.size()); end
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wrhit_reread_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd; int st; bit tmo;
    core_op(1'b1, 32'h0000_2000, 32'h1234_5678, rd, st, tmo);
    n_vec++; if (log_ok(1'b1, 32'h2000, 32'h1234_5678, 1) !== 1'b1) begin n_err++; $display("FAIL wrmiss_request: got %0d reqs want 1 write", req_log.size()); end
    core_op(1'b0, 32'h0000_2000, 32'h0, rd, st, tmo);
    n_vec++; if (log_ok(1'b0, 32'h2000, 32'h0, 4) !== 1'b1) begin n_err++; $display("FAIL wrmiss_no_alloc: got %0d reqs want 4 reads", req_log.size()); end
    n_vec++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL wrmiss_data: got %h want 12345678", rd); end
    m_base[0] = 32'h2000;
  endtask

  task automatic test_conflict();
    logic [31:0] rd; int st; bit tmo;
    core_op(1'b0, 32'h0000_0104, 32'h0, rd, st, tmo);
    n_vec++; if (log_ok(1'b0, 32'h100, 32'h0, 4) !== 1'b1) begin n_err++; $display("FAIL conf_first: got %0d reqs want 4", req_log.size()); end
    core_op(1'b0, 32'h0000_1104, 32'h0, rd, st, tmo);
    n_vec++; if (log_ok(1'b0, 32'h1100, 32'h0, 4) !== 1'b1) begin n_err++; $display("FAIL conf_evict: got %0d reqs want 4", req_log.size()); end
    n_vec++; if (rd !== mem_rd(32'h1104)) begin n_err++; $display("FAIL conf_data: got %h want %h", rd, mem_rd(32'h1104)); end
    core_op(1'b0, 32'h0000_0104, 32'h0, rd, st, tmo);
    n_vec++; if (log_ok(1'b0, 32'h100, 32'h0, 4) !== 1'b1) begin n_err++; $display("FAIL conf_remiss: got %0d reqs want 4", req_log.size()); end
    n_vec++; if (rd !== 32'hA1) begin n_err++; $display("FAIL conf_redata: got %h want 000000a1", rd); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd; int st; bit tmo; int c;
    apply_reset();
    ack_delay = 2;
    req_log.delete();
    @(negedge clk);
    dCacheAddr = 32'h0000_0104;
    dCacheReadEn = 1'b1;
    c = 0;
    while (req_log.size() < 2 && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    n_vec++; if (req_log.size() !== 2) begin n_err++; $display("FAIL midrst_acks: got %0d acks want 2", req_log.size()); end
    @(negedge clk);
    rst = 1'b1;
    dCacheReadEn = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (memReadEn !== 1'b0) begin n_err++; $display("FAIL midrst_readEn: got %b want 0", memReadEn); end
    n_vec++; if (memAddr !== 32'h0) begin n_err++; $display("FAIL midrst_memAddr: got %h want 0", memAddr); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    core_op(1'b0, 32'h0000_0104, 32'h0, rd, st, tmo);
    n_vec++; if (log_ok(1'b0, 32'h100, 32'h0, 4) !== 1'b1) begin n_err++; $display("FAIL midrst_full_refill: got %0d reqs want 4", req_log.size()); end
    n_vec++; if (rd !== 32'hA1) begin n_err++; $display("FAIL midrst_data: got %h want 000000a1", rd); end
    m_valid[0] = 1'b1; m_base[0] = 32'h100;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, base, wdata, exp_rd; int st; bit tmo, wr, hit; int li;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      wr = ($urandom_range(0, 99) < 35);
      a = 32'h4000 | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4)
          | (32'($urandom_range(0, 3)) << 2);
      wdata = $urandom;
      ack_delay = $urandom_range(1, 3);
      base = a & ~32'hF;
      li = int'((a >> 4) & 32'hF);
      hit = m_valid[li] && (m_base[li] == base);
      exp_rd = mem_rd(a);
      core_op(wr, a, wdata, rd, st, tmo);
      n_vec++; if (tmo) begin n_err++; $display("FAIL rnd_timeout: op %0d addr %h", i, a); end
      if (wr) begin
        n_vec++; if (log_ok(1'b1, a, wdata, 1) !== 1'b1) begin n_err++; $display("FAIL rnd_write: op %0d addr %h got %0d reqs want 1", i, a, req_log.size()); end
      end else begin
        if (hit) begin
          n_vec++; if (st !== 0 || req_log.size() !== 0) begin n_err++; $display("FAIL rnd_hit: op %0d addr %h got %0d stalls %0d reqs want 0 0", i, a, st, req_log.size()); end
        end else begin
          n_vec++; if (log_ok(1'b0, base, 32'h0, 4) !== 1'b1) begin n_err++; $display("FAIL rnd_refill: op %0d addr %h got %0d reqs want 4", i, a, req_log.size()); end
          m_valid[li] = 1'b1;
          m_base[li] = base;
        end
        n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL rnd_data: op %0d addr %h got %h want %h", i, a, rd, exp_rd); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Responder to the core's DCache interface (dCacheAddr / dCacheReadEn / dCacheWriteEn / dCacheWriteData / dCacheReadData).
- Adds a stall back to the core and initiates line refills and word writes on a simple request/ack memory bus.
- Sits between mipsCore and main memory.

Parameters:
- NUM_LINES, 16, number of cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- dCacheAddr  input  32  byte address from core; bits [1:0] ignored.
- dCacheWriteData  input  32  store data.
- dCacheWriteEn  input  1  store request; held by core while dCacheStall=1.
- dCacheReadEn  input  1  load request; held by core while dCacheStall=1.
- dCacheReadData  output  32  load data; valid when ReadEn=1 and dCacheStall=0.
- dCacheStall  output  1  core must hold its request and freeze.
- memAddr  output  32  word-aligned memory address.
- memReadEn  output  1  memory read request.
- memWriteEn  output  1  memory write request.
- memWriteData  output  32  memory write data.
- memReadData  input  32  memory read data; valid with memAck.
- memAck  input  1  one-cycle completion pulse for the current request.

Behaviour:
- Address split, with OFF = log2(WORDS_PER_LINE) and IDX = log2(NUM_LINES):
  - word = addr[2+OFF-1:2]
  - index = addr[2+OFF+IDX-1:2+OFF]
  - tag = addr[31:2+OFF+IDX]
- Storage: valid bit, tag and WORDS_PER_LINE data words per line. The data array is read asynchronously.
- Reset (synchronous, rst=1 at posedge):
  - All valid bits cleared, state=IDLE, refill counter=0.
  - memReadEn=0, memWriteEn=0, memAddr=0, memWriteData=0.
  - dCacheStall=0 when no request is present; dCacheReadData=0.
  - Reset overrides every state, including mid-refill and mid-write.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - No request: dCacheStall=0.
  - ReadEn and hit (valid & tag match): dCacheReadData = selected word combinationally, dCacheStall=0; zero-cycle latency, no state change.
  - ReadEn and miss: dCacheStall=1 combinationally. Next state REFILL with counter=0; the line's valid bit is cleared at the same edge.
  - WriteEn (hit or miss): dCacheStall=1 combinationally. Next state WRITE with memAddr and memWriteData latched.
  - ReadEn and WriteEn both high: treated as a write.
- REFILL:
  - Drives memReadEn=1 and memAddr={tag, index, counter, 2'b00}; dCacheStall=1.
  - On memAck: memReadData is written into word[counter] and counter increments.
  - Ack on word WORDS_PER_LINE-1: tag written, valid set, counter wraps to 0, next state IDLE.
  - Refill order is always word 0 upward; there is no critical-word-first.
  - The held request then hits in IDLE that cycle and stall drops.
- WRITE:
  - memWriteEn=1 and dCacheStall=1 until memAck.
  - On memAck, if the line is valid and the tag matches, the cached word is updated with memWriteData. A miss does not allocate.
  - Next state IDLE; stall drops and the core advances, so the core does not reissue the write.
- memAck while neither memReadEn nor memWriteEn is asserted: ignored.
- memReadEn and memWriteEn are never high together.
- Request fields are sampled from the held core inputs. The core must not change them while stalled; behaviour is undefined if it does.
- Reset mid-refill: the line stays invalid, because valid is set only on the final ack. No partial line is ever visible.

Decomposition:
- Package dcache_pkg:
  - Enum dcache_state_t {IDLE, REFILL, WRITE}.
  - Localparam helper functions for the OFF/IDX/TAG widths.
  - Struct dcache_addr_t {tag, index, word, byte}.
- Sub-module dcache_array:
  - Valid/tag/data storage.
  - Asynchronous read port, synchronous write port per word, valid-clear and tag-set ports.
- The top level holds the FSM, refill counter and memory-bus drivers.

Test Plan:
1. Cold read miss: after reset, ReadEn at 0x0000_0104; memory returns 0xA0, 0xA1, 0xA2, 0xA3 for 0x100..0x10C, each acked 2 cycles after request -> exactly 4 memReadEn requests at 0x100, 0x104, 0x108, 0x10C in order; stall high throughout; then dCacheReadData=0xA1 with stall=0.
2. Read hit: after test 1, ReadEn at 0x10C -> dCacheReadData=0xA3 in the same cycle, stall=0, no memory activity.
3. Write hit: WriteEn at 0x108, data 0xDEAD_BEEF -> one memWriteEn at 0x108 with 0xDEADBEEF; stall until ack; subsequent read of 0x108 hits with 0xDEADBEEF.
4. Write miss: WriteEn at 0x2000 -> one memWriteEn at 0x2000; a following read of 0x2000 misses and refills, proving no allocation.
5. Conflict eviction: read 0x0000_0104, then 0x0000_1104 (same index, different tag) -> second access refills; re-reading 0x104 misses again.
6. Reset mid-refill: rst=1 after 2 of 4 acks -> memReadEn=0 the next cycle; a re-read of 0x104 performs a full 4-word refill starting at 0x100.
